// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: default widths, bytes per
// instruction word, the HALT word and the FSM state encoding.
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds the CHK state.
package inst_loader_pkg;

  localparam int unsigned DEF_INST_BITS = 32;
  localparam int unsigned DEF_NBITS     = 8;
  localparam int unsigned WORD_BYTES    = DEF_INST_BITS / DEF_NBITS;

  // Writing this word ends the session.
  localparam logic [DEF_INST_BITS-1:0] HALT_WORD = '1;

`ifdef INST_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4,
    ST_CHK   = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;
`endif

endpackage

// File: rtl/inst_loader_byte_assembler.sv
// Shifts received bytes into one instruction word, first byte ending up in
// the most significant position. word/word_ready present the completed word
// combinationally in the cycle its last byte is strobed, so the caller can
// register it on that same edge.
module byte_assembler
  import inst_loader_pkg::*;
#(
  parameter int unsigned NBITS      = DEF_NBITS,
  parameter int unsigned WORD_BYTES_P = WORD_BYTES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        en,
  input  logic [NBITS-1:0]            data,
  input  logic                        valid,
  output logic [NBITS*WORD_BYTES_P-1:0] word,
  output logic                        word_ready
);

  localparam int unsigned W  = NBITS * WORD_BYTES_P;
  localparam int unsigned CW = (WORD_BYTES_P > 1) ? $clog2(WORD_BYTES_P) : 1;

  logic [W-1:0]  shift_q;
  logic [CW-1:0] count_q;
  logic          take;
  logic          last;

  assign take       = en && valid;
  assign last       = take && (count_q == CW'(WORD_BYTES_P - 1));
  assign word       = {shift_q[W-NBITS-1:0], data};
  assign word_ready = last;

  // Shift register and byte counter; the counter wraps after a full word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the shift register is a plain storage array yet is still reset,
      // so a half-assembled word can never leak into the next session.
      shift_q <= '0;
      count_q <= '0;
    end else if (clear) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (take) begin
      shift_q <= word;
      count_q <= last ? '0 : count_q + CW'(1);
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction loader: assembles received bytes into words and writes them to
// an instruction memory through a SETUP/WRITE handshake, advancing the address
// by 4 per word until a HALT word or the last memory word.
// Optional feature macro: INST_LOADER_CHECKSUM_EN -- after HALT, one extra
// byte is compared with the XOR of all session bytes (o_chk_err on mismatch).
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int unsigned INST_BITS = DEF_INST_BITS,
  parameter int unsigned NBITS     = DEF_NBITS,
  parameter int unsigned CELLS     = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [NBITS-1:0]     i_rx_data,
  input  logic                 i_rx_valid,
  output logic [INST_BITS-1:0] o_dbg_addr,
  output logic [INST_BITS-1:0] o_dbg_inst,
  output logic                 o_dbg_wr_en,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_full
`ifdef INST_LOADER_CHECKSUM_EN
  ,
  output logic                 o_chk_err
`endif
);

  localparam int unsigned        NB        = INST_BITS / NBITS;
  localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - 4);
  localparam logic [INST_BITS-1:0] HALT      = INST_BITS'(HALT_WORD);

  state_t                state_q;
  state_t                state_d;
  logic [INST_BITS-1:0]  word;
  logic                  word_ready;
  logic                  start_session;
  logic                  is_halt;
  logic                  at_last;

  assign start_session = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign is_halt       = (o_dbg_inst == HALT);
  assign at_last       = (o_dbg_addr == LAST_ADDR);

  byte_assembler #(
    .NBITS        (NBITS),
    .WORD_BYTES_P (NB)
  ) u_asm (
    .clk        (i_clk),
    .rst        (i_rst),
    .clear      (start_session),
    .en         (o_busy),
    .data       (i_rx_data),
    .valid      (i_rx_valid),
    .word       (word),
    .word_ready (word_ready)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples values from before the clock edge, regardless of block order.
    if (!i_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    o_busy      = 1'b0;
    o_dbg_wr_en = 1'b0;
    o_done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) state_d = ST_RECV;
      end
      ST_RECV: begin
        o_busy = 1'b1;
        if (word_ready) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        o_busy  = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        o_busy      = 1'b1;
        o_dbg_wr_en = 1'b1;
        if (is_halt) begin
`ifdef INST_LOADER_CHECKSUM_EN
          state_d = ST_CHK;
`else
          state_d = ST_DONE;
`endif
        end else if (at_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) state_d = ST_RECV;
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (i_rx_valid) state_d = ST_DONE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Address, instruction holding register and session status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_dbg_addr <= '0;
      o_dbg_inst <= '0;
      o_full     <= 1'b0;
    end else begin
      if (start_session) begin
        o_dbg_addr <= '0;
        o_full     <= 1'b0;
      end
      if ((state_q == ST_RECV) && word_ready) o_dbg_inst <= word;
      // The address only advances when another word will follow, so it
      // stays on the last written word and never wraps.
      if ((state_q == ST_WRITE) && !is_halt) begin
        if (at_last) o_full     <= 1'b1;
        else         o_dbg_addr <= o_dbg_addr + INST_BITS'(4);
      end
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [NBITS-1:0] chk_acc_q;

  // Running XOR of session bytes, then the comparison with the trailing byte.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      chk_acc_q <= '0;
      o_chk_err <= 1'b0;
    end else if (start_session) begin
      chk_acc_q <= '0;
      o_chk_err <= 1'b0;
    end else begin
      if (o_busy && i_rx_valid) chk_acc_q <= chk_acc_q ^ i_rx_data;
      if ((state_q == ST_CHK) && i_rx_valid) o_chk_err <= (i_rx_data != chk_acc_q);
    end
  end
`endif

endmodule

// File: tb/tb_inst_loader.sv
// Directed testbench for inst_loader. Inputs change on the falling edge and
// outputs are sampled on the falling edge, half a cycle after the DUT edge.
// Define INST_LOADER_CHECKSUM_EN for both bench and RTL to cover the CHK state.
module tb_inst_loader;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic [31:0] o_dbg_addr;
  logic [31:0] o_dbg_inst;
  logic        o_dbg_wr_en;
  logic        o_busy;
  logic        o_done;
  logic        o_full;
`ifdef INST_LOADER_CHECKSUM_EN
  logic        o_chk_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_inst_q[$];

  always #5 i_clk = ~i_clk;

  inst_loader dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_dbg_addr  (o_dbg_addr),
    .o_dbg_inst  (o_dbg_inst),
    .o_dbg_wr_en (o_dbg_wr_en),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_full      (o_full)
`ifdef INST_LOADER_CHECKSUM_EN
    ,
    .o_chk_err   (o_chk_err)
`endif
  );

  // Record every memory write the way the instruction memory would see it.
  always @(negedge i_clk) begin
    if (o_dbg_wr_en) begin
      wr_addr_q.push_back(o_dbg_addr);
      wr_inst_q.push_back(o_dbg_inst);
    end
  end

  function automatic logic [7:0] xor_bytes(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction

  task automatic drive_byte(input logic [7:0] b);
    @(negedge i_clk);
    i_rx_data  = b;
    i_rx_valid = 1'b1;
  endtask

  task automatic idle_cycle();
    @(negedge i_clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) drive_byte(w[i*8 +: 8]);
    idle_cycle();
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst      = 1'b0;
    i_start    = 1'b0;
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b1;
    wr_addr_q.delete();
    wr_inst_q.delete();
  endtask

  task automatic start_session();
    @(negedge i_clk);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n = 0;
    while (!o_done && n < limit) begin
      @(negedge i_clk);
      n++;
    end
    tests_run++;
    if (o_done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: o_done=%b after %0d cycles, required 1", name, o_done, n);
    end
  endtask

  task automatic wait_not_busy(input int limit);
    int n = 0;
    while (o_busy && n < limit) begin
      @(negedge i_clk);
      n++;
    end
  endtask

  // Supplies the trailing checksum byte when that feature is built in.
  task automatic close_session(input logic [7:0] sum);
`ifdef INST_LOADER_CHECKSUM_EN
    wait_not_busy(10);
    drive_byte(sum);
    idle_cycle();
`else
    if (sum === 8'hxx) $display("unused checksum %h", sum);
`endif
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    tests_run++;
    if ({o_dbg_addr, o_dbg_inst, o_dbg_wr_en, o_busy, o_done, o_full} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: addr=%h inst=%h wr=%b busy=%b done=%b full=%b, required all 0",
               o_dbg_addr, o_dbg_inst, o_dbg_wr_en, o_busy, o_done, o_full);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    // A byte in IDLE must be dropped without starting anything.
    drive_byte(8'hAB);
    idle_cycle();
    @(negedge i_clk);
    tests_run++;
    if ({o_busy, o_dbg_wr_en, o_dbg_inst} !== '0) begin
      tests_failed++;
      $display("FAIL idle_drop: busy=%b wr=%b inst=%h, required 0 0 0", o_busy, o_dbg_wr_en, o_dbg_inst);
    end
  endtask

  task automatic test_single_word();
    do_reset();
    start_session();
    tests_run++;
    if (o_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL start_busy: o_busy=%b, required 1", o_busy);
    end
    drive_byte(8'h20);
    drive_byte(8'h01);
    drive_byte(8'h00);
    drive_byte(8'h05);
    idle_cycle();
    tests_run++;
    if ({o_dbg_wr_en, o_dbg_inst} !== {1'b0, 32'h2001_0005}) begin
      tests_failed++;
      $display("FAIL setup_cycle: wr=%b inst=%h, required 0 20010005", o_dbg_wr_en, o_dbg_inst);
    end
    @(negedge i_clk);
    tests_run++;
    if ({o_dbg_wr_en, o_dbg_addr, o_dbg_inst} !== {1'b1, 32'h0, 32'h2001_0005}) begin
      tests_failed++;
      $display("FAIL write_cycle: wr=%b addr=%h inst=%h, required 1 00000000 20010005",
               o_dbg_wr_en, o_dbg_addr, o_dbg_inst);
    end
    @(negedge i_clk);
    tests_run++;
    if ({o_dbg_wr_en, o_dbg_addr, o_busy} !== {1'b0, 32'h4, 1'b1}) begin
      tests_failed++;
      $display("FAIL after_write: wr=%b addr=%h busy=%b, required 0 00000004 1",
               o_dbg_wr_en, o_dbg_addr, o_busy);
    end
    tests_run++;
    if (wr_addr_q.size() != 1) begin
      tests_failed++;
      $display("FAIL single_write_count: got %0d writes, required 1", wr_addr_q.size());
    end
  endtask

  task automatic test_halt();
    logic [31:0] words[4];
    logic [7:0]  sum;
    words = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'hFFFF_FFFF};
    sum = '0;
    do_reset();
    start_session();
    for (int i = 0; i < 4; i++) begin
      send_word(words[i]);
      sum = sum ^ xor_bytes(words[i]);
      repeat (2) idle_cycle();
    end
    close_session(sum);
    wait_done(20, "halt_done");
    tests_run++;
    if (wr_addr_q.size() != 4) begin
      tests_failed++;
      $display("FAIL halt_write_count: got %0d writes, required 4", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if ({wr_addr_q[i], wr_inst_q[i]} !== {32'(i * 4), words[i]}) begin
          tests_failed++;
          $display("FAIL halt_write_%0d: addr=%h inst=%h, required %h %h",
                   i, wr_addr_q[i], wr_inst_q[i], 32'(i * 4), words[i]);
        end
      end
    end
    tests_run++;
    if ({o_done, o_full, o_busy} !== 3'b100) begin
      tests_failed++;
      $display("FAIL halt_flags: done=%b full=%b busy=%b, required 1 0 0", o_done, o_full, o_busy);
    end
    // Bytes after DONE are ignored, and a fresh start clears the session flags.
    send_word(32'h1234_5678);
    repeat (3) idle_cycle();
    tests_run++;
    if ({wr_addr_q.size() == 4, o_done} !== 2'b11) begin
      tests_failed++;
      $display("FAIL done_drop: writes=%0d done=%b, required 4 1", wr_addr_q.size(), o_done);
    end
    start_session();
    tests_run++;
    if ({o_done, o_busy, o_dbg_addr} !== {2'b01, 32'h0}) begin
      tests_failed++;
      $display("FAIL restart: done=%b busy=%b addr=%h, required 0 1 00000000", o_done, o_busy, o_dbg_addr);
    end
  endtask

  task automatic test_full();
    do_reset();
    start_session();
    for (int i = 0; i < 64; i++) send_word(32'h0100_0000 + 32'(i));
    wait_done(20, "full_done");
    tests_run++;
    if (wr_addr_q.size() != 64) begin
      tests_failed++;
      $display("FAIL full_write_count: got %0d writes, required 64", wr_addr_q.size());
    end else begin
      tests_run++;
      if ({wr_addr_q[63], wr_inst_q[63], wr_addr_q[0]} !== {32'd252, 32'h0100_003F, 32'd0}) begin
        tests_failed++;
        $display("FAIL full_last_write: addr=%h inst=%h first=%h, required 000000fc 0100003f 00000000",
                 wr_addr_q[63], wr_inst_q[63], wr_addr_q[0]);
      end
    end
    tests_run++;
    if ({o_full, o_done, o_busy} !== 3'b110) begin
      tests_failed++;
      $display("FAIL full_flags: full=%b done=%b busy=%b, required 1 1 0", o_full, o_done, o_busy);
    end
    send_word(32'h0200_0000);
    repeat (4) idle_cycle();
    tests_run++;
    if ({wr_addr_q.size() == 64, o_dbg_addr} !== {1'b1, 32'd252}) begin
      tests_failed++;
      $display("FAIL full_65th: writes=%0d addr=%h, required 64 000000fc", wr_addr_q.size(), o_dbg_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[4];
    logic [7:0]  sum;
    words = '{32'hA1B2_C3D4, 32'h0506_0708, 32'h90A0_B0C0, 32'hFFFF_FFFF};
    sum = '0;
    do_reset();
    start_session();
    // Sixteen bytes on consecutive cycles; some land in SETUP and WRITE.
    for (int w = 0; w < 4; w++) begin
      for (int b = 3; b >= 0; b--) drive_byte(words[w][b*8 +: 8]);
      sum = sum ^ xor_bytes(words[w]);
    end
    idle_cycle();
    close_session(sum);
    wait_done(20, "b2b_done");
    tests_run++;
    if (wr_addr_q.size() != 4) begin
      tests_failed++;
      $display("FAIL b2b_write_count: got %0d writes, required 4", wr_addr_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if ({wr_addr_q[i], wr_inst_q[i]} !== {32'(i * 4), words[i]}) begin
          tests_failed++;
          $display("FAIL b2b_write_%0d: addr=%h inst=%h, required %h %h",
                   i, wr_addr_q[i], wr_inst_q[i], 32'(i * 4), words[i]);
        end
      end
    end
  endtask

  task automatic test_reset_in_write();
    do_reset();
    start_session();
    drive_byte(8'h11);
    drive_byte(8'h22);
    drive_byte(8'h33);
    drive_byte(8'h44);
    drive_byte(8'hAA);
    @(negedge i_clk);
    tests_run++;
    if (o_dbg_wr_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_write: wr=%b, required 1", o_dbg_wr_en);
    end
    i_rx_data = 8'hBB;
    i_rx_valid = 1'b1;
    i_rst = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b1;
    i_rx_valid = 1'b0;
    tests_run++;
    if ({o_dbg_addr, o_dbg_inst, o_dbg_wr_en, o_busy, o_done, o_full} !== '0) begin
      tests_failed++;
      $display("FAIL reset_in_write: addr=%h inst=%h wr=%b busy=%b done=%b full=%b, required all 0",
               o_dbg_addr, o_dbg_inst, o_dbg_wr_en, o_busy, o_done, o_full);
    end
    drive_byte(8'h77);
    idle_cycle();
    start_session();
    send_word(32'hCAFE_F00D);
    @(negedge i_clk);
    tests_run++;
    if ({o_dbg_wr_en, o_dbg_addr, o_dbg_inst} !== {1'b1, 32'h0, 32'hCAFE_F00D}) begin
      tests_failed++;
      $display("FAIL reassemble: wr=%b addr=%h inst=%h, required 1 00000000 cafef00d",
               o_dbg_wr_en, o_dbg_addr, o_dbg_inst);
    end
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    do_reset();
    start_session();
    send_word(32'hFFFF_FFFF);
    wait_not_busy(10);
    tests_run++;
    if ({o_busy, o_done} !== 2'b00) begin
      tests_failed++;
      $display("FAIL chk_state: busy=%b done=%b, required 0 0", o_busy, o_done);
    end
    drive_byte(8'h00);
    idle_cycle();
    tests_run++;
    if ({o_done, o_chk_err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL chk_good: done=%b chk_err=%b, required 1 0", o_done, o_chk_err);
    end
    start_session();
    send_word(32'hFFFF_FFFF);
    wait_not_busy(10);
    drive_byte(8'h01);
    idle_cycle();
    tests_run++;
    if ({o_done, o_chk_err} !== 2'b11) begin
      tests_failed++;
      $display("FAIL chk_bad: done=%b chk_err=%b, required 1 1", o_done, o_chk_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_halt();
    test_full();
    test_back_to_back();
    test_reset_in_write();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
